// File: rtl/x9_mc_core.sv
// x9_mc_core: multicycle x9 core with req/ack instruction and data memory ports.
//
// Executes the 9-bit x9 ISA one instruction at a time through a small FSM:
//   FETCH -> EXEC -> (MEM) -> FETCH, with HALT as a terminal state.
// The register file (16 x DW), carry flag, ALU and PC are internal. The LUT
// is external and combinational; it is addressed from IR in every state.
//
// Optional feature: define X9_MC_BUS_TIMEOUT_EN to enable a bus watchdog.
// When enabled, a request left waiting TIMEOUT cycles forces HALT with err=1.
// When not defined, err is tied low and the core waits indefinitely.
//
// Ports:
//   clk, start_n            clock, async active-low reset
//   imem_req/addr/ack/data  instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata  data access handshake
//   dmem_ack/rdata          data completion, load data
//   lut_type/key/data       external LUT lookup (combinational)
//   halt, err               core halted, bus timeout
//   instr_count             saturating retired-instruction counter
module x9_mc_core #(
  parameter int DW       = 8,
  parameter int PCW      = 16,
  parameter int RESET_PC = 0,
  parameter int CNTW     = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            start_n,
  output logic            imem_req,
  output logic [PCW-1:0]  imem_addr,
  input  logic            imem_ack,
  input  logic [8:0]      imem_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_ack,
  input  logic [DW-1:0]   dmem_rdata,
  output logic [2:0]      lut_type,
  output logic [4:0]      lut_key,
  input  logic [7:0]      lut_data,
  output logic            halt,
  output logic            err,
  output logic [CNTW-1:0] instr_count
);

  if (DW < 5 || TIMEOUT < 1) begin : g_bad_param
    $error("x9_mc_core: DW must be >= 5 and TIMEOUT >= 1");
  end

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_SET = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SHF = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;
  localparam logic [2:0] OP_BR  = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  localparam logic [DW-1:0] DW_L = DW'(DW);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  state_t state, state_nxt;

  logic [8:0]          ir;
  logic [PCW-1:0]      pc;
  logic [15:0][DW-1:0] rf;
  logic                carry;
  logic [CNTW-1:0]     cnt;

  // Memory operation captured in EXEC so the bus fields stay stable in MEM.
  logic [DW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [3:0]    mem_dst_q;
  logic          mem_we_q;

  // Decode
  logic [2:0] opcode;
  logic [1:0] funct;
  logic       rt;
  logic [4:0] imm5;
  logic [3:0] rd;
  logic       is_lwr, is_halt, is_mem;

  assign opcode  = ir[8:6];
  assign funct   = ir[1:0];
  assign rt      = ir[5];
  assign imm5    = ir[4:0];
  assign rd      = ir[5:2];
  assign is_lwr  = (opcode == OP_ADD) && (funct == 2'b11);
  assign is_halt = (opcode == OP_NEG) && (funct == 2'b11);
  assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW) || is_lwr;

  // LUT addressing follows IR continuously.
  always_comb begin
    lut_type = 3'd0;
    lut_key  = imm5;
    case (opcode)
      OP_SW: lut_type = 3'd1;
      OP_BR: begin
        lut_type = 3'd2 + {1'b0, funct};
        lut_key  = {1'b0, rd};
      end
      default: ;
    endcase
  end

  // ALU / branch evaluation for EXEC
  logic [DW-1:0]  op_a, op_b, shamt, alu_res;
  logic [DW:0]    sum;
  logic           alu_c, alu_we, br_taken;
  logic [3:0]     alu_dst;
  logic [PCW-1:0] pc_inc, br_tgt;
  logic [CNTW-1:0] cnt_inc;

  assign op_a    = rf[0];
  assign op_b    = rf[1];
  assign shamt   = op_b % DW_L;
  assign pc_inc  = pc + PCW'(1);
  assign br_tgt  = PCW'(lut_data);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNTW'(1);

  always_comb begin
    alu_res  = '0;
    alu_c    = carry;
    alu_we   = 1'b0;
    alu_dst  = rd;
    br_taken = 1'b0;
    sum      = '0;
    case (opcode)
      OP_SET: begin
        alu_res = DW'(imm5);
        alu_dst = {3'b000, rt};
        alu_we  = 1'b1;
      end
      OP_ADD: begin
        case (funct)
          2'b00, 2'b01: begin
            // ADDC folds the carry in; ADD ignores it.
            sum     = {1'b0, op_a} + {1'b0, op_b} +
                      {{DW{1'b0}}, (funct[0] & carry)};
            alu_res = sum[DW-1:0];
            alu_c   = sum[DW];
            alu_we  = 1'b1;
          end
          2'b10: begin
            alu_res = op_a - op_b;
            alu_c   = (op_a >= op_b);
            alu_we  = 1'b1;
          end
          default: ; // LWR completes in MEM
        endcase
      end
      OP_SHF: begin
        case (funct)
          2'b00: begin alu_res = op_a << shamt;            alu_we = 1'b1; end
          2'b01: begin alu_res = $signed(op_a) >>> shamt;  alu_we = 1'b1; end
          2'b10: begin alu_res = op_a >> shamt;            alu_we = 1'b1; end
          default: ; // NOP, still retires
        endcase
      end
      OP_NEG: begin
        case (funct)
          2'b00: begin alu_res = -op_a;       alu_we = 1'b1; end
          2'b01: begin alu_res = op_a & op_b; alu_we = 1'b1; end
          2'b10: begin alu_res = op_a | op_b; alu_we = 1'b1; end
          default: ; // HALT
        endcase
      end
      OP_BR: begin
        case (funct)
          2'b00: br_taken = (op_a == op_b);
          2'b01: br_taken = (op_a != op_b);
          2'b10: br_taken = ($signed(op_a) < $signed(op_b));
          default: br_taken = (op_a < op_b);
        endcase
      end
      OP_MOV: begin
        alu_res = rf[rd];
        alu_dst = {3'b000, ir[1]};
        alu_we  = 1'b1;
      end
      default: ; // LW / SW handled in MEM
    endcase
  end

  // Bus watchdog
  logic tmo;
`ifdef X9_MC_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          bus_wait;
  logic          err_q;

  assign bus_wait = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);
  // Fires on the TIMEOUT-th consecutive cycle a request waits without ack.
  assign tmo      = bus_wait && (tcnt == TW'(TIMEOUT - 1));
  assign err      = err_q;

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= bus_wait ? tcnt + TW'(1) : '0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  // FSM next state and bus outputs. Requests are gated by start_n so an
  // in-flight transaction is dropped the moment reset asserts.
  always_comb begin
    state_nxt  = state;
    imem_req   = start_n && (state == S_FETCH);
    dmem_req   = start_n && (state == S_MEM);
    dmem_we    = start_n && (state == S_MEM) && mem_we_q;
    imem_addr  = pc;
    dmem_addr  = mem_addr_q;
    dmem_wdata = mem_wdata_q;
    halt       = (state == S_HALT);
    case (state)
      S_FETCH: if (imem_req && imem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_halt)     state_nxt = S_HALT;
        else if (is_mem) state_nxt = S_MEM;
        else             state_nxt = S_FETCH;
      end
      S_MEM:   if (dmem_req && dmem_ack) state_nxt = S_FETCH;
      default: ;
    endcase
    if (tmo) state_nxt = S_HALT;
  end

  assign instr_count = cnt;

  // Datapath
  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      ir          <= '0;
      pc          <= PCW'(RESET_PC);
      rf          <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_dst_q   <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (imem_req && imem_ack) ir <= imem_data;
        S_EXEC: begin
          if (alu_we) rf[alu_dst] <= alu_res;
          carry       <= alu_c;
          mem_addr_q  <= is_lwr ? op_a : DW'(lut_data);
          mem_wdata_q <= rf[rt];
          mem_we_q    <= (opcode == OP_SW);
          mem_dst_q   <= is_lwr ? rd : {3'b000, rt};
          if (!is_mem && !is_halt) begin
            pc  <= br_taken ? br_tgt : pc_inc;
            cnt <= cnt_inc;
          end
        end
        S_MEM: begin
          if (dmem_req && dmem_ack) begin
            if (!mem_we_q) rf[mem_dst_q] <= dmem_rdata;
            pc  <= pc_inc;
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x9_mc_core.sv
// Directed bench for x9_mc_core: table of single/dual-op programs plus
// hand-written sequences for branches, wait states, reset abort, wrap,
// counter saturation and the bus watchdog.
module tb_x9_mc_core;
  localparam int DW   = 8;
  localparam int PCW  = 8;
  localparam int CNTW = 3;
  localparam int TMO  = 4;

  localparam logic [8:0] I_HALT = 9'b101_0000_11;
  localparam logic [8:0] I_NOP  = 9'b100_0000_11;
  localparam logic [8:0] I_LW00 = 9'b000_0_00000; // LW R0, key 0 -> addr 0
  localparam logic [8:0] I_LW11 = 9'b000_1_00001; // LW R1, key 1 -> addr 1

  logic            clk = 1'b0;
  logic            start_n;
  logic            imem_req, imem_ack;
  logic [PCW-1:0]  imem_addr;
  logic [8:0]      imem_data;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [2:0]      lut_type;
  logic [4:0]      lut_key;
  logic [7:0]      lut_data;
  logic            halt, err;
  logic [CNTW-1:0] instr_count;

  int total = 0;
  int bad   = 0;

  x9_mc_core #(.DW(DW), .PCW(PCW), .RESET_PC(0), .CNTW(CNTW), .TIMEOUT(TMO)) dut (
    .clk(clk), .start_n(start_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .lut_type(lut_type), .lut_key(lut_key), .lut_data(lut_data),
    .halt(halt), .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Memories with programmable wait states (ack after N waiting cycles).
  logic [8:0] imem [256];
  logic [7:0] dmem [256];
  int   imem_wait, dmem_wait, iw, dwc;
  logic ack_force;
  int   st_cnt;
  logic [7:0] st_addr, st_data;

  assign imem_ack   = (imem_req && iw >= imem_wait) || ack_force;
  assign imem_data  = imem[imem_addr];
  assign dmem_ack   = dmem_req && dwc >= dmem_wait;
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      iw <= 0; dwc <= 0; st_cnt <= 0; st_addr <= '0; st_data <= '0;
    end else begin
      iw  <= (imem_req && !imem_ack) ? iw + 1 : 0;
      dwc <= (dmem_req && !dmem_ack) ? dwc + 1 : 0;
      if (dmem_req && dmem_ack && dmem_we) begin
        st_cnt  <= st_cnt + 1;
        st_addr <= dmem_addr;
        st_data <= dmem_wdata;
      end
    end
  end

  // LUT contents used by the tests.
  function automatic logic [7:0] lut_f(input logic [2:0] t, input logic [4:0] k);
    logic [7:0] kk;
    kk = {3'b000, k};
    case (t)
      3'd0:    lut_f = (k == 5'd7) ? 8'h12 : kk;
      3'd1:    lut_f = 8'h20 + kk;
      3'd2:    lut_f = (k == 5'd14) ? 8'hFF : (k == 5'd15) ? 8'h00 : 8'h60 + kk;
      3'd4:    lut_f = (k == 5'd2) ? 8'h40 : 8'h70 + kk;
      3'd5:    lut_f = 8'h50;
      default: lut_f = 8'h30;
    endcase
  endfunction
  assign lut_data = lut_f(lut_type, lut_key);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    start_n   = 1'b0;
    ack_force = 1'b0;
    imem_wait = 0;
    dmem_wait = 0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = I_HALT;
      dmem[i] = 8'h00;
    end
    dmem[5]    = 8'h77;
    dmem[8'h12] = 8'hA5;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    start_n = 1'b1;
  endtask

  task automatic run_to_halt(input string nm, input int maxc, output int ncyc);
    ncyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (halt) begin
        ncyc = i;
        break;
      end
    end
    if (ncyc < 0) begin
      total++;
      bad++;
      $display("FAIL %s: halt not seen within %0d cycles", nm, maxc);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] a, b;
    logic [8:0] op1, op2;
    logic [3:0] ridx;
    logic [7:0] exp_v;
    logic       exp_c;
  } vec_t;

  initial begin
    vec_t vq[$];
    int   n, hi;
    logic addr_ok;

    // name, R0, R1, op1, op2, checked reg, expected value, expected carry
    vq.push_back('{"add",    8'hF0, 8'h20, 9'b011_0010_00, I_NOP,          4'd2,  8'h10, 1'b1});
    vq.push_back('{"addc",   8'hF0, 8'h20, 9'b011_0010_00, 9'b011_0011_01, 4'd3,  8'h11, 1'b1});
    vq.push_back('{"sub_lt", 8'h05, 8'h07, 9'b011_0100_10, I_NOP,          4'd4,  8'hFE, 1'b0});
    vq.push_back('{"sub_eq", 8'h07, 8'h07, 9'b011_0100_10, I_NOP,          4'd4,  8'h00, 1'b1});
    vq.push_back('{"sll",    8'h81, 8'h09, 9'b100_0101_00, I_NOP,          4'd5,  8'h02, 1'b0});
    vq.push_back('{"sra",    8'h90, 8'h02, 9'b100_0110_01, I_NOP,          4'd6,  8'hE4, 1'b0});
    vq.push_back('{"srl",    8'h90, 8'h0A, 9'b100_0111_10, I_NOP,          4'd7,  8'h24, 1'b0});
    vq.push_back('{"neg",    8'h01, 8'h00, 9'b101_1000_00, I_NOP,          4'd8,  8'hFF, 1'b0});
    vq.push_back('{"and",    8'hF0, 8'h3C, 9'b101_1001_01, I_NOP,          4'd9,  8'h30, 1'b0});
    vq.push_back('{"or",     8'hF0, 8'h0C, 9'b101_1010_10, I_NOP,          4'd10, 8'hFC, 1'b0});
    vq.push_back('{"mov",    8'h12, 8'h34, 9'b011_1011_00, 9'b111_1011_10, 4'd1,  8'h46, 1'b0});
    vq.push_back('{"c_keep", 8'h80, 8'h80, 9'b011_0010_00, 9'b101_0011_01, 4'd3,  8'h80, 1'b1});
    vq.push_back('{"set",    8'h00, 8'h00, 9'b010_1_11111, I_NOP,          4'd1,  8'h1F, 1'b0});
    vq.push_back('{"lwr",    8'h05, 8'h00, 9'b011_1100_11, I_NOP,          4'd12, 8'h77, 1'b0});

    // Reset state
    do_reset();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we",  32'(dmem_we), 32'd0);
    chk("rst_halt",     32'(halt), 32'd0);
    chk("rst_err",      32'(err), 32'd0);
    chk("rst_count",    32'(instr_count), 32'd0);
    chk("rst_pc",       32'(imem_addr), 32'd0);

    // SET R0,5; SET R1,3; ADD R2; HALT
    imem[0] = 9'b010_0_00101;
    imem[1] = 9'b010_1_00011;
    imem[2] = 9'b011_0010_00;
    release_rst();
    run_to_halt("tp", 50, n);
    chk("tp_r2",    32'(dut.rf[2]), 32'h08);
    chk("tp_carry", 32'(dut.carry), 32'd0);
    chk("tp_count", 32'(instr_count), 32'd3);
    // The first fetch completes on the first edge after release; halt is
    // registered 7 cycles after that edge.
    chk("tp_cycles", 32'(n - 1), 32'd7);

    // Table vectors: LW R0; LW R1; op1; op2; HALT
    foreach (vq[k]) begin
      do_reset();
      dmem[0] = vq[k].a;
      dmem[1] = vq[k].b;
      imem[0] = I_LW00;
      imem[1] = I_LW11;
      imem[2] = vq[k].op1;
      imem[3] = vq[k].op2;
      release_rst();
      run_to_halt(vq[k].name, 100, n);
      chk({vq[k].name, "_val"},   32'(dut.rf[vq[k].ridx]), 32'(vq[k].exp_v));
      chk({vq[k].name, "_carry"}, 32'(dut.carry), 32'(vq[k].exp_c));
      chk({vq[k].name, "_count"}, 32'(instr_count), 32'd4);
      chk({vq[k].name, "_pc"},    32'(imem_addr), 32'd4);
    end

    // BLTS taken, R0=0xFF R1=0x01, LUT(4,2)=0x40
    do_reset();
    dmem[0] = 8'hFF; dmem[1] = 8'h01;
    imem[0] = I_LW00; imem[1] = I_LW11; imem[2] = 9'b110_0010_10;
    release_rst();
    run_to_halt("blts", 100, n);
    chk("blts_pc", 32'(imem_addr), 32'h40);
    chk("blts_count", 32'(instr_count), 32'd3);

    // BLT unsigned, same operands: not taken
    do_reset();
    dmem[0] = 8'hFF; dmem[1] = 8'h01;
    imem[0] = I_LW00; imem[1] = I_LW11; imem[2] = 9'b110_0010_11;
    release_rst();
    run_to_halt("blt", 100, n);
    chk("blt_pc", 32'(imem_addr), 32'h03);

    // SW R1 (0x1A) via LUT(1,3)=0x23
    do_reset();
    imem[0] = 9'b010_1_11010;
    imem[1] = 9'b001_1_00011;
    release_rst();
    run_to_halt("sw", 100, n);
    chk("sw_cnt",   32'(st_cnt), 32'd1);
    chk("sw_addr",  32'(st_addr), 32'h23);
    chk("sw_data",  32'(st_data), 32'h1A);
    chk("sw_count", 32'(instr_count), 32'd2);

    // LW R1 with 3 dmem wait states, LUT(0,7)=0x12
    do_reset();
    dmem_wait = 3;
    imem[0] = 9'b000_1_00111;
    release_rst();
    hi = 0;
    addr_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dmem_req) begin
        hi++;
        if (dmem_addr !== 8'h12 || dmem_we !== 1'b0) addr_ok = 1'b0;
        if (dmem_ack) begin
          @(negedge clk);
          chk("lw_req_drop", 32'(dmem_req), 32'd0);
          break;
        end
      end
    end
    chk("lw_req_cycles", 32'(hi), 32'd4);
    chk("lw_addr_stable", 32'(addr_ok), 32'd1);
    run_to_halt("lw_wait", 50, n);
    chk("lw_r1", 32'(dut.rf[1]), 32'hA5);

    // Reset asserted in the middle of the second fetch, ack pending
    do_reset();
    imem_wait = 3;
    imem[0] = 9'b010_0_00101;
    imem[1] = 9'b010_1_00011;
    imem[2] = 9'b011_0010_00;
    release_rst();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("abort_req_before", 32'(imem_req), 32'd1);
    chk("abort_pc_before",  32'(imem_addr), 32'd1);
    #2;
    start_n   = 1'b0;
    ack_force = 1'b1;
    #1;
    chk("abort_req_now", 32'(imem_req), 32'd0);
    chk("abort_pc_now",  32'(imem_addr), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_count", 32'(instr_count), 32'd0);
    chk("abort_r0",    32'(dut.rf[0]), 32'd0);
    ack_force = 1'b0;
    start_n   = 1'b1;
    run_to_halt("abort_rerun", 200, n);
    chk("abort_r2",    32'(dut.rf[2]), 32'h08);
    chk("abort_count_after", 32'(instr_count), 32'd3);

    // PC wrap: BEQ to 0xFF, SET R0,9 at 0xFF wraps to 0, BEQ falls through
    do_reset();
    imem[0]     = 9'b110_1110_00;
    imem[8'hFF] = 9'b010_0_01001;
    release_rst();
    run_to_halt("wrap", 100, n);
    chk("wrap_pc",    32'(imem_addr), 32'd1);
    chk("wrap_r0",    32'(dut.rf[0]), 32'd9);
    chk("wrap_count", 32'(instr_count), 32'd3);

    // Saturation: BEQ-to-self loop retires every 2 cycles
    do_reset();
    imem[0] = 9'b110_1111_00;
    release_rst();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sat_mid", 32'(instr_count), 32'd5);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sat_full", 32'(instr_count), 32'd7);
    chk("sat_halt", 32'(halt), 32'd0);

    // Fetch never acknowledged
    do_reset();
    imem_wait = 100000;
`ifdef X9_MC_BUS_TIMEOUT_EN
    release_rst();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tmo_err_early", 32'(err), 32'd0);
    chk("tmo_halt_early", 32'(halt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_err",  32'(err), 32'd1);
    chk("tmo_halt", 32'(halt), 32'd1);
    chk("tmo_req",  32'(imem_req), 32'd0);
`else
    release_rst();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("notmo_err",  32'(err), 32'd0);
    chk("notmo_halt", 32'(halt), 32'd0);
    chk("notmo_req",  32'(imem_req), 32'd1);
    chk("notmo_pc",   32'(imem_addr), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
